vga_scaled: RTL and testbench

VGA_SCALED -- requirements
Module: vga_scaled

---
 rtl/vga_scaled.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_vga_scaled.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scaled.sv
// VGA timing generator that upscales a SRC_W x SRC_H RGB332 framebuffer by SCALE,
// prefetching one source row ahead into ping-pong line buffers. Optional: VGA_TEST_PATTERN_EN.
module vga_scaled #(
    parameter int unsigned H     = 640,
    parameter int unsigned HFP   = 16,
    parameter int unsigned HS    = 96,
    parameter int unsigned HBP   = 48,
    parameter int unsigned V     = 400,
    parameter int unsigned VFP   = 12,
    parameter int unsigned VS    = 2,
    parameter int unsigned VBP   = 35,
    parameter int unsigned SCALE = 4,
    parameter int unsigned AW    = 16
) (
    input  logic          pclk,
    input  logic          reset,
    output logic          fb_rd_req,
    output logic [AW-1:0] fb_rd_addr,
    input  logic [7:0]    fb_rd_data,
    input  logic          fb_rd_valid,
    input  logic          test_en,
    output logic          hs,
    output logic          vs,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b,
    output logic          VGA_HB,
    output logic          VGA_VB,
    output logic          VGA_DE,
    output logic          frame_start,
    output logic          underflow
);

    localparam int unsigned HT    = H + HFP + HS + HBP;
    localparam int unsigned VT    = V + VFP + VS + VBP;
    localparam int unsigned SRC_W = H / SCALE;
    localparam int unsigned SRC_H = V / SCALE;
    localparam int unsigned HW    = (HT > 1) ? $clog2(HT) : 1;
    localparam int unsigned VW    = (VT > 1) ? $clog2(VT) : 1;
    localparam int unsigned CW    = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int unsigned RW    = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int unsigned SW    = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HW-1:0] H_LAST      = HW'(HT - 1);
    localparam logic [HW-1:0] H_VIS       = HW'(H);
    localparam logic [HW-1:0] H_VIS_LAST  = HW'(H - 1);
    localparam logic [HW-1:0] H_SYNC      = HW'(H + HFP);
    localparam logic [HW-1:0] H_SYNC_LAST = HW'(H + HFP + HS - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(VT - 1);
    localparam logic [VW-1:0] V_VIS       = VW'(V);
    localparam logic [VW-1:0] V_VIS_LAST  = VW'(V - 1);
    localparam logic [VW-1:0] V_SYNC      = VW'(V + VFP);
    localparam logic [VW-1:0] V_SYNC_LAST = VW'(V + VFP + VS - 1);
    localparam logic [SW-1:0] REP_LAST    = SW'(SCALE - 1);
    localparam logic [CW-1:0] COL_LAST    = CW'(SRC_W - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(SRC_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } fetch_st_e;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [CW-1:0] hcol_q, hcol_d;
    logic [SW-1:0] hrep_q, hrep_d;
    logic [RW-1:0] vrow_q, vrow_d;
    logic [SW-1:0] vrep_q, vrep_d;

    fetch_st_e     st_q, st_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          sel_q, sel_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          uf_q, uf_d;

    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          hb_q, hb_d;
    logic          vb_q, vb_d;
    logic          de_q, de_d;
    logic          fs_q, fs_d;
    logic [7:0]    r_q, r_d;
    logic [7:0]    g_q, g_d;
    logic [7:0]    b_q, b_d;

    logic [7:0]    lbuf [2][SRC_W];
    logic          wr_en_c;
    logic          trig0_c;
    logic          trign_c;
    logic          swap_c;
    logic          test_c;
    logic [7:0]    pix_c;

    // Pixel source: framebuffer line buffer, or colour bars when the pattern is built and selected
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_c;
    logic [7:0] pat_c;

    assign test_c = test_en;

    always_comb begin : pattern_pixel
        bar_c = 3'((32'(h_q) * 32'd8) / 32'(H));
        pat_c = 8'h00;
        case (bar_c)
            3'd0:    pat_c = 8'hFF;
            3'd1:    pat_c = 8'hFC;
            3'd2:    pat_c = 8'h1F;
            3'd3:    pat_c = 8'h1C;
            3'd4:    pat_c = 8'hE3;
            3'd5:    pat_c = 8'hE0;
            3'd6:    pat_c = 8'h03;
            default: pat_c = 8'h00;
        endcase
        pix_c = test_en ? pat_c : lbuf[sel_q][hcol_q];
    end
`else
    logic unused_test_en;

    assign unused_test_en = test_en;
    assign test_c         = 1'b0;
    assign pix_c          = lbuf[sel_q][hcol_q];
`endif

    // Raster counters; hcol/hrep and vrow/vrep track h_cnt/SCALE and v_cnt/SCALE without dividers
    always_comb begin : timing_next
        h_d    = h_q;
        v_d    = v_q;
        hcol_d = hcol_q;
        hrep_d = hrep_q;
        vrow_d = vrow_q;
        vrep_d = vrep_q;
        if (h_q == H_LAST) begin
            h_d    = '0;
            hcol_d = '0;
            hrep_d = '0;
        end else begin
            h_d = h_q + HW'(1);
            if (h_q < H_VIS_LAST) begin
                if (hrep_q == REP_LAST) begin
                    hrep_d = '0;
                    hcol_d = hcol_q + CW'(1);
                end else begin
                    hrep_d = hrep_q + SW'(1);
                end
            end
        end
        if (h_q == H_SYNC) begin
            if (v_q == V_LAST) begin
                v_d    = '0;
                vrow_d = '0;
                vrep_d = '0;
            end else begin
                v_d = v_q + VW'(1);
                if (v_q < V_VIS_LAST) begin
                    if (vrep_q == REP_LAST) begin
                        vrep_d = '0;
                        vrow_d = vrow_q + RW'(1);
                    end else begin
                        vrep_d = vrep_q + SW'(1);
                    end
                end
            end
        end
    end

    assign trig0_c = (h_q == H_SYNC) && (v_q == V_SYNC);
    assign trign_c = (h_q == '0) && (v_q < V_VIS) && (vrep_q == '0) && (vrow_q < ROW_LAST);
    assign swap_c  = (h_q == H_SYNC) &&
                     (((v_q < V_VIS) && (vrep_q == REP_LAST)) || (v_q == V_LAST));

    // Fetch FSM: one outstanding read, swap aborts an unfinished fill and flags underflow
    always_comb begin : fetch_next
        st_d    = st_q;
        col_d   = col_q;
        row_d   = row_q;
        sel_d   = sel_q;
        uf_d    = uf_q;
        addr_d  = addr_q;
        req_d   = 1'b0;
        wr_en_c = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (trig0_c || trign_c) begin
                    st_d  = ST_REQ;
                    col_d = '0;
                    row_d = trig0_c ? '0 : vrow_q + RW'(1);
                end
            end
            ST_REQ: st_d = ST_WAIT;
            ST_WAIT: begin
                if (fb_rd_valid) begin
                    wr_en_c = 1'b1;
                    if (col_q == COL_LAST) begin
                        st_d = ST_IDLE;
                    end else begin
                        col_d = col_q + CW'(1);
                        st_d  = ST_REQ;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
        if (swap_c) begin
            sel_d = ~sel_q;
            if (st_q != ST_IDLE) begin
                st_d = ST_IDLE;
                if (!test_c) begin
                    uf_d = 1'b1;
                end
            end
        end
        if (test_c) begin
            st_d    = ST_IDLE;
            wr_en_c = 1'b0;
        end
        req_d = (st_d == ST_REQ);
        if (req_d) begin
            addr_d = AW'(row_d) * AW'(SRC_W) + AW'(col_d);
        end
    end

    // Video outputs, all derived from the current counter state
    always_comb begin : video_next
        hb_d = (h_q >= H_VIS);
        vb_d = (v_q >= V_VIS);
        de_d = !hb_d && !vb_d;
        hs_d = !((h_q >= H_SYNC) && (h_q <= H_SYNC_LAST));
        vs_d = (v_q >= V_SYNC) && (v_q <= V_SYNC_LAST);
        fs_d = (h_q == '0) && (v_q == '0);
        r_d  = 8'h00;
        g_d  = 8'h00;
        b_d  = 8'h00;
        if (de_d) begin
            r_d = {pix_c[7:5], pix_c[7:5], pix_c[7:6]};
            g_d = {pix_c[4:2], pix_c[4:2], pix_c[4:3]};
            b_d = {pix_c[1:0], pix_c[1:0], pix_c[1:0], pix_c[1:0]};
        end
    end

    always_ff @(posedge pclk or posedge reset) begin : state_regs
        if (reset) begin
            h_q    <= '0;
            v_q    <= '0;
            hcol_q <= '0;
            hrep_q <= '0;
            vrow_q <= '0;
            vrep_q <= '0;
            st_q   <= ST_IDLE;
            col_q  <= '0;
            row_q  <= '0;
            sel_q  <= 1'b0;
            req_q  <= 1'b0;
            addr_q <= '0;
            uf_q   <= 1'b0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b0;
            hb_q   <= 1'b0;
            vb_q   <= 1'b0;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
            r_q    <= 8'h00;
            g_q    <= 8'h00;
            b_q    <= 8'h00;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            hcol_q <= hcol_d;
            hrep_q <= hrep_d;
            vrow_q <= vrow_d;
            vrep_q <= vrep_d;
            st_q   <= st_d;
            col_q  <= col_d;
            row_q  <= row_d;
            sel_q  <= sel_d;
            req_q  <= req_d;
            addr_q <= addr_d;
            uf_q   <= uf_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            hb_q   <= hb_d;
            vb_q   <= vb_d;
            de_q   <= de_d;
            fs_q   <= fs_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
        end
    end

    // Line buffer storage has no reset; the buffer not on display is the one being filled
    always_ff @(posedge pclk) begin : lbuf_write
        if (wr_en_c) begin
            lbuf[~sel_q][col_q] <= fb_rd_data;
        end
    end

    assign fb_rd_req   = req_q;
    assign fb_rd_addr  = addr_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign VGA_HB      = hb_q;
    assign VGA_VB      = vb_q;
    assign VGA_DE      = de_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;

endmodule

// File: tb/tb_vga_scaled.sv
// Directed bench for vga_scaled on a small 32x16 raster (SCALE=2) with a latency-programmable
// framebuffer model that returns addr[7:0] as pixel data.
module tb_vga_scaled;

    localparam int unsigned H = 32, HFP = 2, HS = 4, HBP = 2;
    localparam int unsigned V = 16, VFP = 1, VS = 1, VBP = 1;
    localparam int unsigned SCALE = 2, AW = 8;

    logic          pclk = 1'b0;
    logic          reset = 1'b1;
    logic          fb_rd_req;
    logic [AW-1:0] fb_rd_addr;
    logic [7:0]    fb_rd_data = 8'h00;
    logic          fb_rd_valid = 1'b0;
    logic          test_en = 1'b0;
    logic          hs, vs, VGA_HB, VGA_VB, VGA_DE, frame_start, underflow;
    logic [7:0]    r, g, b;

    vga_scaled #(
        .H(H), .HFP(HFP), .HS(HS), .HBP(HBP),
        .V(V), .VFP(VFP), .VS(VS), .VBP(VBP),
        .SCALE(SCALE), .AW(AW)
    ) dut (
        .pclk(pclk), .reset(reset),
        .fb_rd_req(fb_rd_req), .fb_rd_addr(fb_rd_addr),
        .fb_rd_data(fb_rd_data), .fb_rd_valid(fb_rd_valid),
        .test_en(test_en),
        .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
        .VGA_HB(VGA_HB), .VGA_VB(VGA_VB), .VGA_DE(VGA_DE),
        .frame_start(frame_start), .underflow(underflow)
    );

    always #5 pclk = ~pclk;

    int n_tests = 0, n_fail = 0;
    int pos = 0, frame_len = 0;
    int hs_low = 0, vs_hi = 0, f_hs = 0, f_vs = 0;
    int lat = 1, pend = 0;
    logic [AW-1:0] pend_addr = '0;
    int req_cnt = 0, addr_sum = 0, addr_max = 0;
    int f_req = 0, f_sum = 0, f_max = 0;

    // Framebuffer model: answers each request lat cycles later, driven on the falling edge
    always @(negedge pclk) begin
        if (reset) begin
            pend        = 0;
            fb_rd_valid = 1'b0;
        end else begin
            fb_rd_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    fb_rd_valid = 1'b1;
                    fb_rd_data  = 8'(pend_addr);
                end
            end
            if (fb_rd_req) begin
                pend      = lat;
                pend_addr = fb_rd_addr;
                req_cnt++;
                addr_sum += int'(fb_rd_addr);
                if (int'(fb_rd_addr) > addr_max) addr_max = int'(fb_rd_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
        pos++;
        if (!hs) hs_low++;
        if (vs) vs_hi++;
    endtask

    task automatic clr_stats();
        pos = 0; hs_low = 0; vs_hi = 0;
        req_cnt = 0; addr_sum = 0; addr_max = 0;
    endtask

    // Advance to the next frame_start pulse (bounded) and snapshot the elapsed frame's statistics
    task automatic wait_fs(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 2000);
        check({tag, "_fs"}, 32'(frame_start), 32'd1);
        frame_len = pos;
        f_hs  = hs_low;
        f_vs  = vs_hi;
        f_req = req_cnt;
        f_sum = addr_sum;
        f_max = addr_max;
        clr_stats();
    endtask

    task automatic at(input int k);
        while (pos < k) step();
    endtask

    task automatic check_px(input string tag, input int k, input logic [23:0] exp);
        at(k);
        check(tag, 32'({r, g, b}), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_ctrl", 32'({hs, vs, VGA_HB, VGA_VB, VGA_DE, frame_start, underflow, fb_rd_req}),
              32'h80);
        check("rst_rgb", 32'({r, g, b}), 32'h0);
        check("rst_addr", 32'(fb_rd_addr), 32'h0);
        reset = 1'b0;
        step();
        check("fs_first", 32'(frame_start), 32'd1);
        clr_stats();

        wait_fs("f1");
        check("f0_len", 32'(frame_len), 32'd760);

        // Frame 1: rows fetched with 1-cycle latency, data = address
        check_px("px_v0_h0", 0, 24'h000000);
        check("de_v0_h0", 32'(VGA_DE), 32'd1);
        check_px("px_v0_h2", 2, 24'h000055);
        check_px("px_v0_h4", 4, 24'h0000AA);
        check_px("px_v0_h31", 31, 24'h006DFF);
        at(32);
        check("hb_h32", 32'({VGA_HB, VGA_DE}), 32'b10);
        check("rgb_h32", 32'({r, g, b}), 32'h0);
        at(33); check("hs_h33", 32'(hs), 32'd1);
        at(34); check("hs_h34", 32'(hs), 32'd0);
        at(37); check("hs_h37", 32'(hs), 32'd0);
        at(38); check("hs_h38", 32'(hs), 32'd1);
        check_px("px_v1_h2", 42, 24'h000055);
        check_px("px_v2_h0", 80, 24'h009200);
        check_px("px_v2_h10", 90, 24'h00B655);
        check_px("px_v4_h0", 160, 24'h240000);
        check_px("px_v15_h31", 631, 24'h6DFFFF);
        at(640);
        check("vb_v16", 32'({VGA_VB, VGA_DE}), 32'b10);
        check("rgb_v16", 32'({r, g, b}), 32'h0);
        at(674); check("vs_before", 32'(vs), 32'd0);
        at(675); check("vs_start", 32'(vs), 32'd1);
        at(714); check("vs_end", 32'(vs), 32'd1);
        at(715); check("vs_after", 32'(vs), 32'd0);

        wait_fs("f2");
        check("f1_len", 32'(frame_len), 32'd760);
        check("f1_hs_low", 32'(f_hs), 32'd76);
        check("f1_vs_hi", 32'(f_vs), 32'd40);
        check("f1_reads", 32'(f_req), 32'd128);
        check("f1_addr_sum", 32'(f_sum), 32'd8128);
        check("f1_addr_max", 32'(f_max), 32'd127);
        check("f1_uflow", 32'(underflow), 32'd0);

        // Slow framebuffer: 5 cycles per read cannot fill a row in time
        lat = 4;
        wait_fs("f3");
        check("slow_uflow", 32'(underflow), 32'd1);
        check("slow_len", 32'(frame_len), 32'd760);
        check("slow_hs_low", 32'(f_hs), 32'd76);

        // Reset in the middle of a fetch
        n = 0;
        while (!fb_rd_req && n < 200) begin
            step();
            n++;
        end
        check("mid_req_seen", 32'(fb_rd_req), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_ctrl", 32'({hs, vs, VGA_HB, VGA_VB, VGA_DE, frame_start, underflow, fb_rd_req}),
              32'h80);
        check("arst_rgb", 32'({r, g, b}), 32'h0);
        check("arst_addr", 32'(fb_rd_addr), 32'h0);
        repeat (3) step();
        check("hold_ctrl", 32'({hs, vs, VGA_DE, frame_start, underflow, fb_rd_req}), 32'h20);
        lat = 1;
        reset = 1'b0;
        step();
        check("rec_fs", 32'(frame_start), 32'd1);
        check("rec_de", 32'(VGA_DE), 32'd1);
        clr_stats();
        wait_fs("rec");
        check("rec_len", 32'(frame_len), 32'd760);
        check("rec_reads", 32'(f_req), 32'd128);
        check("rec_uflow", 32'(underflow), 32'd0);

`ifdef VGA_TEST_PATTERN_EN
        test_en = 1'b1;
        wait_fs("tp0");
        check("tp_px0", 32'({r, g, b}), 32'h00FFFFFF);
        check_px("tp_px4", 4, 24'hFFFF00);
        check_px("tp_px8", 8, 24'h00FFFF);
        wait_fs("tp1");
        check("tp_reads", 32'(f_req), 32'd0);
        check("tp_uflow", 32'(underflow), 32'd0);
        test_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
